// File: rtl/data_mem_responder.sv
// data_mem_responder: 512-byte little-endian load/store responder; word-crossing accesses split over two beats.
// Define MISALIGN_TRAP_EN to reject crossing accesses with misalign_err instead of splitting them.
module data_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_funct3,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_busy,
    output logic              o_misalign_err
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rd_data, r_lo, r_sp_data;
    logic              r_rd_valid, r_sp_ld;
    logic [3:0]        r_sp_be;
    logic [1:0]        r_sp_off;
    logic [2:0]        r_sp_f3;
    logic [IDX_W-1:0]  r_sp_idx;

    logic [IDX_W-1:0]  w_idx, w_we_idx;
    logic [1:0]        w_off;
    logic              w_busy, w_ld, w_st, w_ld_ok, w_st_ok, w_cross, w_xing, w_split, w_trap, w_we;
    logic [3:0]        w_mask, w_we_be;
    logic [7:0]        w_be;
    logic [63:0]       w_wd;
    logic [31:0]       w_we_data;

    function automatic logic [31:0] ld_fmt(input logic [63:0] d, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] s;
        s = 32'(d >> {off, 3'b000});
        return f3 == 3'b000 ? {{24{s[7]}}, s[7:0]}  :
               f3 == 3'b001 ? {{16{s[15]}}, s[15:0]} :
               f3 == 3'b010 ? s                      :
               f3 == 3'b100 ? {24'b0, s[7:0]}        :
               f3 == 3'b101 ? {16'b0, s[15:0]}       : 32'b0;
    endfunction

    assign w_idx   = i_addr[ADDR_W-1:2];
    assign w_off   = i_addr[1:0];
    assign w_busy  = r_state == SPLIT;
    assign w_st    = i_wr && !w_busy;
    assign w_ld    = i_rd && !i_wr && !w_busy;
    assign w_ld_ok = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign w_st_ok = i_funct3 inside {3'b000, 3'b001, 3'b010};
    assign w_cross = (i_funct3[1:0] == 2'b10 && w_off != 2'b00) || (i_funct3[1:0] == 2'b01 && w_off == 2'b11);
    assign w_xing  = ((w_ld && w_ld_ok) || (w_st && w_st_ok)) && w_cross;
`ifdef MISALIGN_TRAP_EN
    assign w_split = 1'b0;
    assign w_trap  = w_xing;
`else
    assign w_split = w_xing;
    assign w_trap  = 1'b0;
`endif
    assign w_mask  = i_funct3[1:0] == 2'b00 ? 4'b0001 : i_funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    assign w_be    = {4'b0000, w_mask} << w_off;
    assign w_wd    = {32'b0, i_wr_data} << {w_off, 3'b000};

    // The SPLIT beat owns the write port; otherwise a fresh store writes its first-word bytes.
    assign w_we      = i_rst_n && (w_busy ? !r_sp_ld : (w_st && w_st_ok && !w_trap));
    assign w_we_idx  = w_busy ? r_sp_idx  : w_idx;
    assign w_we_be   = w_busy ? r_sp_be   : w_be[3:0];
    assign w_we_data = w_busy ? r_sp_data : w_wd[31:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE && w_split) w_next = SPLIT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_lo       <= '0;
            r_sp_data  <= '0;
            r_sp_ld    <= 1'b0;
            r_sp_be    <= '0;
            r_sp_off   <= '0;
            r_sp_f3    <= '0;
            r_sp_idx   <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_busy) begin
                if (r_sp_ld) begin
                    r_rd_data  <= ld_fmt({r_mem[r_sp_idx], r_lo}, r_sp_off, r_sp_f3);
                    r_rd_valid <= 1'b1;
                end
            end else if (w_split) begin
                r_sp_ld   <= w_ld;
                r_lo      <= r_mem[w_idx];
                r_sp_off  <= w_off;
                r_sp_f3   <= i_funct3;
                r_sp_idx  <= w_idx + 1'b1;
                r_sp_be   <= w_be[7:4];
                r_sp_data <= w_wd[63:32];
            end else if (w_ld) begin
                r_rd_data  <= w_trap ? 32'b0 : ld_fmt({32'b0, r_mem[w_idx]}, w_off, i_funct3);
                r_rd_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we)
            for (int b = 0; b < 4; b++)
                if (w_we_be[b]) r_mem[w_we_idx][8*b +: 8] <= w_we_data[8*b +: 8];
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign_err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_misalign_err <= 1'b0;
        else          r_misalign_err <= w_trap;
    end
    assign o_misalign_err = r_misalign_err;
`else
    assign o_misalign_err = 1'b0;
`endif

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_busy     = w_busy;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder; expectations follow MISALIGN_TRAP_EN when defined.
module tb_data_mem_responder;
    logic        clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [8:0]  addr = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd_data;
    logic        rd_valid, busy, merr;
    int          checks = 0, failures = 0;

    data_mem_responder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_rd(rd), .i_addr(addr), .i_funct3(f3),
        .i_wr_data(wdata), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy), .o_misalign_err(merr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
        wr = 1'b1; addr = a; f3 = f; wdata = d;
        step();
        wr = 1'b0;
        if (busy) step();
    endtask

    task automatic load(input logic [8:0] a, input logic [2:0] f, output logic [31:0] q, output logic v);
        rd = 1'b1; addr = a; f3 = f;
        step();
        rd = 1'b0;
        if (busy) step();
        q = rd_data; v = rd_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr = 1'b1; rd = 1'b1; addr = 9'h010; f3 = 3'b010;
        step(); step();
        checks++;
        if ({rd_data, rd_valid, busy, merr} !== 35'b0) begin
            failures++;
            $display("FAIL reset data=%h valid=%b busy=%b merr=%b expected all 0", rd_data, rd_valid, busy, merr);
        end
        wr = 1'b0; rd = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word();
        logic [31:0] q; logic v;
        store(9'h010, 3'b010, 32'hDEADBEEF);
        load(9'h010, 3'b010, q, v);
        checks++;
        if (v !== 1'b1 || q !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_word valid=%b data=%h expected 1 deadbeef", v, q);
        end
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL lw_valid_drop valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_ext();
        logic [8:0]  ta [4] = '{9'h013, 9'h013, 9'h010, 9'h010};
        logic [2:0]  tf [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] te [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000BEEF};
        logic [31:0] q; logic v;
        for (int i = 0; i < 4; i++) begin
            load(ta[i], tf[i], q, v);
            checks++;
            if (v !== 1'b1 || q !== te[i]) begin
                failures++;
                $display("FAIL ext_%0d addr=%h f3=%b valid=%b data=%h expected 1 %h", i, ta[i], tf[i], v, q, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  ta [4] = '{9'h010, 9'h013, 9'h011, 9'h012};
        logic [2:0]  tf [4] = '{3'b010, 3'b100, 3'b001, 3'b101};
        logic [31:0] te [4] = '{32'hDEADBEEF, 32'h000000DE, 32'hFFFFADBE, 32'h0000DEAD};
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = ta[i]; f3 = tf[i];
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== te[i] || busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_%0d valid=%b busy=%b data=%h expected 1 0 %h", i, rd_valid, busy, rd_data, te[i]);
            end
        end
        rd = 1'b0;
        step();
    endtask

    task automatic test_partial();
        logic [31:0] q; logic v;
        store(9'h012, 3'b001, 32'h00001234);
        load(9'h010, 3'b010, q, v);
        checks++;
        if (v !== 1'b1 || q !== 32'h1234BEEF) begin
            failures++;
            $display("FAIL sh_then_lw valid=%b data=%h expected 1 1234beef", v, q);
        end
        store(9'h014, 3'b010, 32'h11223344);
        rd = 1'b1; addr = 9'h012; f3 = 3'b010;
        step();
        rd = 1'b0;
`ifdef MISALIGN_TRAP_EN
        checks++;
        if (merr !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL trap_lw merr=%b valid=%b busy=%b data=%h expected 1 1 0 0", merr, rd_valid, busy, rd_data);
        end
        step();
        checks++;
        if (merr !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL trap_lw_drop merr=%b busy=%b expected 0 0", merr, busy);
        end
        wr = 1'b1; addr = 9'h012; f3 = 3'b010; wdata = 32'hFFFFFFFF;
        step();
        wr = 1'b0;
        checks++;
        if (merr !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL trap_sw merr=%b valid=%b busy=%b expected 1 0 0", merr, rd_valid, busy);
        end
        load(9'h010, 3'b010, q, v);
        checks++;
        if (q !== 32'h1234BEEF) begin
            failures++;
            $display("FAIL trap_sw_nochange data=%h expected 1234beef", q);
        end
`else
        checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL split_lw_beat1 busy=%b valid=%b expected 1 0", busy, rd_valid);
        end
        step();
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 32'h33441234) begin
            failures++;
            $display("FAIL split_lw_result busy=%b valid=%b data=%h expected 0 1 33441234", busy, rd_valid, rd_data);
        end
`endif
    endtask

    task automatic test_invalid();
        logic [31:0] q; logic v;
        store(9'h010, 3'b011, 32'hFFFFFFFF);
        load(9'h010, 3'b010, q, v);
        checks++;
        if (q !== 32'h1234BEEF) begin
            failures++;
            $display("FAIL bad_store_nochange data=%h expected 1234beef", q);
        end
        load(9'h010, 3'b111, q, v);
        checks++;
        if (v !== 1'b1 || q !== 32'h0) begin
            failures++;
            $display("FAIL bad_load valid=%b data=%h expected 1 0", v, q);
        end
    endtask

    task automatic test_simul();
        logic [31:0] q; logic v;
        wr = 1'b1; rd = 1'b1; addr = 9'h020; f3 = 3'b000; wdata = 32'h00000055;
        step();
        wr = 1'b0; rd = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_no_valid valid=%b expected 0", rd_valid);
        end
        load(9'h020, 3'b100, q, v);
        checks++;
        if (v !== 1'b1 || q !== 32'h00000055) begin
            failures++;
            $display("FAIL wr_rd_byte valid=%b data=%h expected 1 00000055", v, q);
        end
    endtask

    task automatic test_stall();
        rd = 1'b1; addr = 9'h012; f3 = 3'b010;
        step();
        addr = 9'h010;
        step();
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 32'h33441234) begin
            failures++;
            $display("FAIL stall_first busy=%b valid=%b data=%h expected 0 1 33441234", busy, rd_valid, rd_data);
        end
        step();
        rd = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1234BEEF) begin
            failures++;
            $display("FAIL stall_held valid=%b data=%h expected 1 1234beef", rd_valid, rd_data);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [31:0] q; logic v;
        wr = 1'b1; addr = 9'h1FE; f3 = 3'b010; wdata = 32'hAABBCCDD;
        step();
        wr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL wrap_busy busy=%b expected 1", busy);
        end
        step();
        load(9'h000, 3'b101, q, v);
        checks++;
        if (v !== 1'b1 || q !== 32'h0000AABB) begin
            failures++;
            $display("FAIL wrap_low valid=%b data=%h expected 1 0000aabb", v, q);
        end
        load(9'h1FE, 3'b101, q, v);
        checks++;
        if (v !== 1'b1 || q !== 32'h0000CCDD) begin
            failures++;
            $display("FAIL wrap_high valid=%b data=%h expected 1 0000ccdd", v, q);
        end
    endtask

    task automatic test_reset_split();
        logic [31:0] q; logic v;
        store(9'h024, 3'b010, 32'h99887766);
        wr = 1'b1; addr = 9'h023; f3 = 3'b010; wdata = 32'h11223344;
        step();
        wr = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_split busy=%b valid=%b expected 0 0", busy, rd_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        load(9'h023, 3'b100, q, v);
        checks++;
        if (q !== 32'h00000044) begin
            failures++;
            $display("FAIL rst_beat1 data=%h expected 00000044", q);
        end
        load(9'h024, 3'b100, q, v);
        checks++;
        if (q !== 32'h00000066) begin
            failures++;
            $display("FAIL rst_beat2 data=%h expected 00000066", q);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_ext();
        test_back_to_back();
        test_partial();
        test_invalid();
        test_simul();
`ifndef MISALIGN_TRAP_EN
        test_stall();
        test_wrap();
        test_reset_split();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far side of the core's load/store port (wr, rd, addr, wr_data, rd_data).
- Byte-addressed, little-endian, 512-byte synchronous RAM organised as 128 x 32-bit words with byte lanes.
- Decodes access size from funct3: byte, half or word, signed or unsigned.
- Misaligned accesses that cross a word boundary are split into two beats by a small FSM, with a busy stall back to the core.

Parameters:
- DATA_W, 32, data width; must be 32.
- ADDR_W, 9, byte-address width; memory size is 2**ADDR_W bytes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr  input  1  store request, sampled when busy=0.
- rd  input  1  load request, sampled when busy=0.
- addr  input  ADDR_W  byte address.
- funct3  input  3  access size and signedness.
- wr_data  input  DATA_W  store data; the low bytes are used for sb/sh.
- rd_data  output  DATA_W  registered load result.
- rd_valid  output  1  one-cycle pulse when rd_data is valid.
- busy  output  1  high while the second beat of a split access is in progress; new requests are ignored.
- misalign_err  output  1  misalignment pulse; only meaningful with MISALIGN_TRAP_EN, otherwise tied 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values:
  - rd_data=0, rd_valid=0, busy=0, misalign_err=0, FSM=IDLE.
  - RAM contents are not reset.
- funct3 decode:
  - Loads: 000 lb (sign-extend), 001 lh (sign-extend), 010 lw, 100 lbu (zero-extend), 101 lhu (zero-extend).
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other code: no RAM change. A load with such a code returns rd_data=0 with rd_valid=1 after the normal latency.
- Priority: wr and rd both high → the write is performed, the read is dropped, rd_valid stays 0.
- Aligned or non-crossing access (byte address + size − 1 stays in the same word):
  - Store: commits on the sampling edge; byte enables come from addr[1:0] and the size.
  - Load: rd_data and rd_valid=1 appear the cycle after sampling (latency 1). rd_valid drops the following cycle unless a new load is sampled.
  - Back-to-back loads give one result per cycle.
- Crossing access (lw with addr[1:0]≠0, or lh/lhu with addr[1:0]=3):
  - IDLE→SPLIT on the sampling edge. busy=1 for exactly one cycle (the SPLIT cycle).
  - Beat 1 covers bytes in word addr[8:2]. Beat 2 covers bytes in word (addr[8:2]+1) mod 128; the top word wraps to word 0.
  - Store: beat-1 bytes commit on the IDLE edge, beat-2 bytes on the SPLIT edge.
  - Load: beat-1 bytes are held in an internal register. The result is assembled at the SPLIT edge. rd_valid pulses the cycle after SPLIT (latency 2 from the request). SPLIT→IDLE always.
- Requests presented while busy=1 are ignored; the core must hold them until busy=0.
- Read-after-write: a load sampled the cycle after a store returns the updated bytes.
- Reset asserted mid-SPLIT:
  - FSM goes to IDLE, busy=0, no rd_valid.
  - Beat-1 bytes of a split store that already committed remain written; beat 2 is lost.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Crossing accesses are not split and the SPLIT state is unreachable.
  - Stores: no RAM change.
  - Loads: return rd_data=0 with rd_valid=1 at latency 1.
  - misalign_err pulses for one cycle, aligned with where rd_valid would be (the cycle after sampling) for both stores and loads.
  - busy is constantly 0.
- Undefined: split behaviour as above; misalign_err tied 0.

Test Plan:
- Word store/load: sw 0xDEADBEEF @0x010, then lw @0x010 → next cycle rd_valid=1, rd_data=0xDEADBEEF; rd_valid=0 the cycle after.
- Byte sign and zero extension: lb @0x013 → 0xFFFFFFDE. lbu @0x013 → 0x000000DE. lh @0x010 → 0xFFFFBEEF. lhu @0x010 → 0x0000BEEF.
- Partial store and misaligned load:
  - sh 0x00001234 @0x012, then lw @0x010 → 0x1234BEEF.
  - sw 0x11223344 @0x014, then lw @0x012 → busy=1 for one cycle, rd_valid two cycles after the request, rd_data=0x33441234.
  - With MISALIGN_TRAP_EN: lw @0x012 → misalign_err pulse, rd_data=0, busy never high.
- Wrap-around split store: sw 0xAABBCCDD @0x1FE, then lhu @0x000 → 0x0000AABB, and lhu @0x1FE → 0x0000CCDD.
- Simultaneous and stall cases:
  - wr=rd=1 with sb 0x55 @0x020 → byte written, no rd_valid; a later lbu @0x020 → 0x00000055.
  - A request held during busy is accepted only once busy=0.
- Reset mid-SPLIT: assert reset during the SPLIT of sw 0x11223344 @0x023 → busy=0 and rd_valid=0 immediately. After release:
  - lbu @0x023 → 0x00000044 (beat 1 committed).
  - lbu @0x024 retains its pre-test value (beat 2 not written).
